mem_responder: RTL

//   Word-addressed memory responder on the far side of the MAR/MDR memory interface.
//   The datapath/control unit initiates read or write; this block answers after a

---
 rtl/mem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory on the far side of the MAR/MDR interface.
// Accepts one read or write request in IDLE, waits a fixed number of cycles,
// commits on the edge entering RESP and pulses done for one cycle.
//
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous reset, active-low
//   read, write  request strobes, level-sampled only while idle (write wins)
//   address      word address
//   mem_data_in  write data
//   Mdatain      registered read data, holds until the next read commits
//   ready        high only while idle
//   done         one-cycle completion pulse
module mem_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              ready,
  output logic              done
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   mdatain_q, mdatain_d;
  logic                commit;
  logic                mem_we;

  logic [DATA_W-1:0]   mem_q [Depth];

  // WAIT always lasts WAIT_STATES+1 cycles: the counter holds the extra cycles
  // still to go, and the final WAIT cycle (counter at zero) is the array access
  // itself. This gives done in the cycle after edge N+WAIT_STATES+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write || read) begin
          addr_d  = address;
          data_d  = mem_data_in;
          wr_d    = write;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_we    = commit && wr_q;
  assign mdatain_d = (commit && !wr_q) ? mem_q[addr_q] : mdatain_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      mdatain_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      mdatain_q <= mdatain_d;
    end
  end

  // Array is deliberately not reset; reset aborts via the FSM, so no commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign Mdatain = mdatain_q;
  assign ready   = (state_q == StIdle);
  assign done    = (state_q == StResp);

endmodule
